// File: rtl/mod_divider_sequencer.sv
// Run-controller for a programmable modulo counter / square-wave divider.
// Steps a modulo-N counter, toggles square on each wrap, and pulses done after the requested wraps.
module mod_divider_sequencer #(
  parameter int CW = 3,
  parameter int PW = 4
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] modulus,
  input  logic [PW-1:0] periods,
  input  logic          pause,
  input  logic          abort,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          tick,
  output logic          square,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] mod_q, mod_d;
  logic [PW-1:0] per_q, per_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wrap_q, wrap_d;
  logic          tick_q, tick_d;
  logic          square_q, square_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] wrap_inc_s;

  assign wrap_inc_s = wrap_q + {{(PW-1){1'b0}}, 1'b1};

  // Next-state and next-output logic; pulse outputs default low every cycle.
  always_comb begin
    state_d  = state_q;
    mod_d    = mod_q;
    per_d    = per_q;
    count_d  = count_q;
    wrap_d   = wrap_q;
    square_d = square_q;
    busy_d   = busy_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((modulus >= CW'(2)) && (periods != {PW{1'b0}})) begin
            mod_d    = modulus;
            per_d    = periods;
            count_d  = {CW{1'b0}};
            wrap_d   = {PW{1'b0}};
            square_d = 1'b0;
            busy_d   = 1'b1;
            state_d  = RUN;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          count_d  = {CW{1'b0}};
          square_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (pause) begin
          state_d = RUN;
        end else if (count_q == (mod_q - CW'(1))) begin
          // Wrap against the latched modulus; the live input is ignored mid-run.
          count_d  = {CW{1'b0}};
          tick_d   = 1'b1;
          square_d = ~square_q;
          wrap_d   = wrap_inc_s;
          if (wrap_inc_s == per_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        count_d  = {CW{1'b0}};
        square_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mod_q    <= {CW{1'b0}};
      per_q    <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      wrap_q   <= {PW{1'b0}};
      tick_q   <= 1'b0;
      square_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mod_q    <= mod_d;
      per_q    <= per_d;
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      tick_q   <= tick_d;
      square_q <= square_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign count  = count_q;
  assign tick   = tick_q;
  assign square = square_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mod_divider_sequencer.sv
// Directed self-checking bench for mod_divider_sequencer.
// Outputs are packed as {busy, count, tick, square, done, err} and compared on falling edges.
module tb_mod_divider_sequencer;

  localparam int CW = 3;
  localparam int PW = 4;

  logic          clock;
  logic          rst;
  logic          start;
  logic [CW-1:0] modulus;
  logic [PW-1:0] periods;
  logic          pause;
  logic          abort;
  logic          busy;
  logic [CW-1:0] count;
  logic          tick;
  logic          square;
  logic          done;
  logic          err;
  logic [7:0]    obs;
  logic [7:0]    exp_v;

  int errors = 0;
  int checks = 0;

  mod_divider_sequencer #(.CW(CW), .PW(PW)) dut (
    .clock   (clock),
    .rst     (rst),
    .start   (start),
    .modulus (modulus),
    .periods (periods),
    .pause   (pause),
    .abort   (abort),
    .busy    (busy),
    .count   (count),
    .tick    (tick),
    .square  (square),
    .done    (done),
    .err     (err)
  );

  assign obs = {busy, count, tick, square, done, err};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; modulus = 3'd0; periods = 4'd0; pause = 1'b0; abort = 1'b0;
    #1;
    exp_v = 8'h00;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset: got %b want %b", obs, exp_v); end
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_idle: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_nominal;
    start = 1'b1; modulus = 3'd6; periods = 4'd2;
    @(negedge clock);
    start = 1'b0;
    exp_v = {1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL nominal_accept: got %b want %b", obs, exp_v); end
    for (int k = 1; k <= 13; k++) begin
      @(negedge clock);
      exp_v = {(k < 12), (k >= 12) ? 3'd0 : 3'(k % 6), (k == 6 || k == 12),
               (k >= 6 && k < 12), (k == 12), 1'b0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL nominal_edge%0d: got %b want %b", k, obs, exp_v); end
    end
  endtask

  task automatic test_pause;
    start = 1'b1; modulus = 3'd3; periods = 4'd1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    exp_v = {1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pause_pre: got %b want %b", obs, exp_v); end
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL pause_hold%0d: got %b want %b", k, obs, exp_v); end
    end
    pause = 1'b0;
    @(negedge clock);
    exp_v = {1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pause_resume: got %b want %b", obs, exp_v); end
    @(negedge clock);
    exp_v = {1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pause_done_edge7: got %b want %b", obs, exp_v); end
    @(negedge clock);
    exp_v = {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pause_idle: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_reject;
    start = 1'b1; modulus = 3'd1; periods = 4'd5;
    @(negedge clock);
    start = 1'b0;
    exp_v = {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reject_mod1: got %b want %b", obs, exp_v); end
    @(negedge clock);
    exp_v = {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reject_err_clear: got %b want %b", obs, exp_v); end
    start = 1'b1; modulus = 3'd4; periods = 4'd0;
    @(negedge clock);
    start = 1'b0;
    exp_v = {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reject_per0: got %b want %b", obs, exp_v); end
    start = 1'b1; modulus = 3'd4; periods = 4'd1;
    @(negedge clock);
    start = 1'b0;
    exp_v = {1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reject_then_accept: got %b want %b", obs, exp_v); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      exp_v = {(k < 4), (k >= 4) ? 3'd0 : 3'(k), (k == 4), (k >= 4), (k == 4), 1'b0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reject_run_edge%0d: got %b want %b", k, obs, exp_v); end
    end
  endtask

  task automatic test_abort;
    start = 1'b1; modulus = 3'd5; periods = 4'd3;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      exp_v = {1'b1, 3'(k % 5), (k == 5), (k >= 5), 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL abort_run_edge%0d: got %b want %b", k, obs, exp_v); end
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    exp_v = 8'h00;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL abort_stop: got %b want %b", obs, exp_v); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL abort_no_done%0d: got %b want %b", k, obs, exp_v); end
    end
  endtask

  task automatic test_simultaneous;
    start = 1'b1; modulus = 3'd2; periods = 4'd2;
    @(negedge clock);
    start = 1'b0;
    exp_v = {1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL simul_accept: got %b want %b", obs, exp_v); end
    @(negedge clock);
    abort = 1'b1; pause = 1'b1;
    @(negedge clock);
    abort = 1'b0; pause = 1'b0;
    exp_v = 8'h00;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL simul_abort_wins: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_ignored_start;
    start = 1'b1; modulus = 3'd3; periods = 4'd1;
    @(negedge clock);
    modulus = 3'd7; periods = 4'd0;
    exp_v = {1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ign_accept: got %b want %b", obs, exp_v); end
    @(negedge clock);
    exp_v = {1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ign_edge1: got %b want %b", obs, exp_v); end
    @(negedge clock);
    exp_v = {1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ign_edge2: got %b want %b", obs, exp_v); end
    @(negedge clock);
    exp_v = {1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ign_done: got %b want %b", obs, exp_v); end
    @(negedge clock);
    start = 1'b0;
    exp_v = {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ign_idle: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_async_reset;
    start = 1'b1; modulus = 3'd6; periods = 4'd2;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    exp_v = {1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL areset_pre: got %b want %b", obs, exp_v); end
    #2;
    rst = 1'b1;
    #1;
    exp_v = 8'h00;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL areset_immediate: got %b want %b", obs, exp_v); end
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL areset_idle: got %b want %b", obs, exp_v); end
    start = 1'b1; modulus = 3'd2; periods = 4'd1;
    @(negedge clock);
    start = 1'b0;
    exp_v = {1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL areset_restart: got %b want %b", obs, exp_v); end
    @(negedge clock);
    @(negedge clock);
    exp_v = {1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL areset_restart_done: got %b want %b", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_pause();
    test_reject();
    test_abort();
    test_simultaneous();
    test_ignored_start();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_divider_sequencer.md
Name: mod_divider_sequencer

Overview:
Run-controller for a programmable modulo counter / square-wave divider datapath.
Accepts a start request with a modulus and a period count, then steps the modulo counter and toggles the divided output on every wrap.
Signals completion after the requested number of wraps.
Sits between control logic (buttons/switch debouncers or a top-level FSM) and the display/LED outputs driven by the divider.

Parameters:
CW, 3, modulo counter width in bits; legal modulus range is 2..2^CW-1.
PW, 4, period-count width in bits; legal period range is 1..2^PW-1.

Ports:
clock  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request to begin a run; sampled only in IDLE.
modulus  input  CW  counter modulus, latched on accepted start.
periods  input  PW  number of wraps to run, latched on accepted start.
pause  input  1  while high in RUN, freezes count, wrap counter and square.
abort  input  1  while high in RUN, terminates the run without done.
busy  output  1  high while in RUN.
count  output  CW  current modulo count, 0..modulus-1.
tick  output  1  one-cycle pulse on each counter wrap.
square  output  1  divided output; toggles on each wrap.
done  output  1  one-cycle pulse after the final wrap.
err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; count=0, tick=0, square=0, done=0, err=0, busy=0; latched modulus and periods cleared to 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, RUN, DONE.
- IDLE, start=1, modulus>=2 and periods>=1:
  - latch modulus and periods;
  - count=0, wrap counter=0, square=0;
  - next state RUN; busy=1 from that edge.
- IDLE, start=1 with modulus<2 or periods==0: err=1 for one cycle; stay IDLE; latched values unchanged.
- RUN, per edge, priority abort > pause > advance.
  - abort=1: next state IDLE; count=0, square=0, busy=0; no tick, no done.
  - pause=1: hold count, wrap counter and square; tick=0.
  - advance, count<mod-1: count+1; tick=0.
  - advance, count==mod-1:
    - count=0, tick=1, square toggles, wrap counter+1;
    - if the new wrap count equals periods: next state DONE, done=1, busy=0 at the same edge.
- DONE: lasts exactly one cycle; done is high during it. Next edge: state=IDLE, done=0, tick=0. square keeps its last value until the next accepted start.
- Latency: done rises modulus*periods edges after the start-acceptance edge, plus paused cycles.
- start while in RUN or DONE is ignored; err is not raised.
- tick and done are each high for exactly one cycle per event. err is never high outside IDLE.
- Width rules:
  - count compares against the latched modulus, never the live input.
  - The wrap counter is PW bits and cannot overflow because periods<=2^PW-1.
- Changing modulus or periods mid-run has no effect.
- rst asserted mid-run returns all state to reset values immediately, including in DONE.

Test Plan:
- Nominal run. Stimulus: reset, then start=1 for one cycle with modulus=6, periods=2.
  - busy=1 from the next cycle; count runs 0,1,2,3,4,5,0...
  - tick pulses at edges 6 and 12 after acceptance; square goes 0→1→0.
  - done=1 for one cycle starting at edge 12; busy drops at edge 12; IDLE at edge 13.
- Pause. Stimulus: modulus=3, periods=1, with pause=1 for 4 cycles starting at count=1.
  - count holds at 1 for those 4 cycles.
  - done arrives at edge 7 instead of edge 3; no tick while paused.
- Rejection.
  - start with modulus=1, periods=5: err one cycle, busy stays 0.
  - start with modulus=4, periods=0: err one cycle, busy stays 0.
  - A following valid start is accepted normally.
- Abort. Stimulus: modulus=5, periods=3, abort pulsed at count=3 of the second period.
  - Next edge: busy=0, count=0, square=0.
  - No done pulse; a new start is then accepted.
- Simultaneous events and ignored start.
  - abort and pause both high on a wrap cycle: abort wins, no tick.
  - start pulsed during RUN: run unaffected, no err.
- Asynchronous reset. Assert rst between clock edges mid-run with count=4.
  - All outputs go to 0 without waiting for a clock edge.
  - After rst deasserts, state is IDLE and a new start is accepted.
